// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side bus responder.
// State encodings and the wait-state counter width live here.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE  = 2'd0,
        MR_WAIT  = 2'd1,
        MR_DONE  = 2'd2,
        MR_DRAIN = 2'd3
    } mr_state_e;

    localparam int MR_CNT_W    = 4;
    localparam int MR_MAX_WAIT = (1 << MR_CNT_W) - 1;

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM with a registered read port.
// The array is never reset; rdata holds its value until the next read.
module mem_word_array #(
    parameter int DATA_W   = 32,
    parameter int MEM_LOG2 = 10
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [MEM_LOG2-1:0] idx,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [2**MEM_LOG2];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Bus responder: decodes a word-address window and serves level-held read/write
// requests from a local RAM after a fixed wait-state count, with four-phase done.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MEM_LOG2    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_q,
    input  logic              write_q,
    output logic [DATA_W-1:0] data_out,
    output logic              read_dn,
    output logic              write_dn,
    output logic              bus_busy,
    output logic              proto_err
);

    localparam logic [MR_CNT_W-1:0] WAIT_INIT = MR_CNT_W'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > MR_MAX_WAIT) begin : g_bad_wait
            $error("mem_responder: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    mr_state_e             state_q, state_d;
    logic [MR_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [MEM_LOG2-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  read_dn_q, read_dn_d;
    logic                  write_dn_q, write_dn_d;
    logic                  busy_q, busy_d;
    logic                  perr_q, perr_d;
    logic                  rq_prev_q, rq_prev_d;
    logic                  wq_prev_q, wq_prev_d;

    logic [ADDR_W-1:0]     offset;
    logic                  hit;
    logic                  req_held;
    logic                  opp_req;
    logic                  opp_prev;
    logic                  mem_we;
    logic                  mem_re;
    logic [MEM_LOG2-1:0]   mem_idx;
    logic [DATA_W-1:0]     mem_rdata;

    assign offset = addr_in - BASE_ADDR;
    assign hit    = (addr_in >= BASE_ADDR) && ((offset >> MEM_LOG2) == '0);

    // The RAM read is issued one edge before the access edge so that its
    // registered output is ready to be copied into data_out at the access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_wr_d    = op_wr_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        read_dn_d  = read_dn_q;
        write_dn_d = write_dn_q;
        perr_d     = 1'b0;
        rq_prev_d  = read_q;
        wq_prev_d  = write_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_idx    = idx_q;
        req_held   = op_wr_q ? write_q : read_q;
        opp_req    = op_wr_q ? read_q : write_q;
        opp_prev   = op_wr_q ? rq_prev_q : wq_prev_q;

        case (state_q)
            MR_IDLE: begin
                if (hit) begin
                    if (read_q && write_q) begin
                        perr_d = !(rq_prev_q && wq_prev_q);
                    end else if (read_q || write_q) begin
                        state_d = MR_WAIT;
                        cnt_d   = WAIT_INIT;
                        op_wr_d = write_q;
                        idx_d   = offset[MEM_LOG2-1:0];
                        wdata_d = data_in;
                        if (read_q && WAIT_CYCLES == 0) begin
                            mem_re  = 1'b1;
                            mem_idx = offset[MEM_LOG2-1:0];
                        end
                    end
                end
            end
            MR_WAIT: begin
                if (!req_held) begin
                    state_d = MR_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1 && !op_wr_q) begin
                        mem_re = 1'b1;
                    end
                end else begin
                    state_d = MR_DONE;
                    if (op_wr_q) begin
                        mem_we     = 1'b1;
                        write_dn_d = 1'b1;
                    end else begin
                        data_out_d = mem_rdata;
                        read_dn_d  = 1'b1;
                    end
                end
            end
            MR_DONE: begin
                if (opp_req && !opp_prev) begin
                    perr_d = 1'b1;
                end
                if (!req_held) begin
                    read_dn_d  = 1'b0;
                    write_dn_d = 1'b0;
                    state_d    = MR_DRAIN;
                end
            end
            MR_DRAIN: state_d = MR_IDLE;
            default:  state_d = MR_IDLE;
        endcase

        busy_d = (state_d != MR_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MR_IDLE;
            cnt_q      <= '0;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            read_dn_q  <= 1'b0;
            write_dn_q <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            rq_prev_q  <= 1'b0;
            wq_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_wr_q    <= op_wr_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            data_out_q <= data_out_d;
            read_dn_q  <= read_dn_d;
            write_dn_q <= write_dn_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
            rq_prev_q  <= rq_prev_d;
            wq_prev_q  <= wq_prev_d;
        end
    end

    mem_word_array #(
        .DATA_W   (DATA_W),
        .MEM_LOG2 (MEM_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (mem_idx),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign data_out  = data_out_q;
    assign read_dn   = read_dn_q;
    assign write_dn  = write_dn_q;
    assign bus_busy  = busy_q;
    assign proto_err = perr_q;

endmodule
